// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared pipeline constants, ALU op classes and control bundle
package riscv_pkg;

    localparam int XLEN      = 64;
    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_ITYPE = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    branch;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_ZERO = '0;

    // x0 is hardwired to zero, so a write to it must never be forwarded.
    function automatic logic bypass_hit(input logic                 we,
                                        input logic [REG_IDX_W-1:0] wb_rd,
                                        input logic [REG_IDX_W-1:0] rs);
        return we && (wb_rd != '0) && (wb_rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - ID-side, WB-side and EX-side signals of the ID/EX stage
interface id_ex_stage_if
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 16
);
    logic                 id_valid;
    logic [XLEN-1:0]      id_pc, id_read_data1, id_read_data2, id_imm;
    logic [REG_IDX_W-1:0] id_rs1, id_rs2, id_rd;
    logic [3:0]           id_funct4;
    logic                 id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch;
    logic [1:0]           id_alu_op;

    logic                 wb_reg_write;
    logic [REG_IDX_W-1:0] wb_rd;
    logic [XLEN-1:0]      wb_write_data;

    logic                 flush;
    logic                 stall;

    logic                 ex_valid;
    logic [XLEN-1:0]      ex_pc, ex_read_data1, ex_read_data2, ex_imm;
    logic [REG_IDX_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic [3:0]           ex_funct4;
    logic                 ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch;
    logic [1:0]           ex_alu_op;
    logic [CNT_W-1:0]     stall_count;

    modport master (
        output id_valid, id_pc, id_read_data1, id_read_data2, id_imm, id_rs1, id_rs2, id_rd,
               id_funct4, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
               id_branch, id_alu_op, wb_reg_write, wb_rd, wb_write_data, flush,
        input  stall, ex_valid, ex_pc, ex_read_data1, ex_read_data2, ex_imm, ex_rs1, ex_rs2,
               ex_rd, ex_funct4, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_alu_src, ex_branch, ex_alu_op, stall_count
    );

    modport slave (
        input  id_valid, id_pc, id_read_data1, id_read_data2, id_imm, id_rs1, id_rs2, id_rd,
               id_funct4, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src,
               id_branch, id_alu_op, wb_reg_write, wb_rd, wb_write_data, flush,
        output stall, ex_valid, ex_pc, ex_read_data1, ex_read_data2, ex_imm, ex_rs1, ex_rs2,
               ex_rd, ex_funct4, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_alu_src, ex_branch, ex_alu_op, stall_count
    );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - load-use compare between EX load and ID sources
module hazard_detect
    import riscv_pkg::*;
(
    input  logic                 ex_valid_i,
    input  logic                 ex_mem_read_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 id_valid_i,
    input  logic [REG_IDX_W-1:0] id_rs1_i,
    input  logic [REG_IDX_W-1:0] id_rs2_i,
    output logic                 hazard_o
);
    // rs2 is compared even for I-type; the occasional false stall is cheaper than decoding it.
    assign hazard_o = id_valid_i && ex_valid_i && ex_mem_read_i && (ex_rd_i != '0) &&
                      ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass and load-use bubble
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 16
)(
    input logic           clk,
    input logic           reset,
    id_ex_stage_if.slave  bus
);
    logic                 hazard;
    logic                 bubble;
    ctrl_t                id_ctrl;

    logic                 valid_d, valid_q;
    logic [XLEN-1:0]      pc_d, pc_q, rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
    logic [REG_IDX_W-1:0] rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [3:0]           funct4_d, funct4_q;
    ctrl_t                ctrl_d, ctrl_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;

    hazard_detect u_hazard (
        .ex_valid_i    (valid_q),
        .ex_mem_read_i (ctrl_q.mem_read),
        .ex_rd_i       (rd_q),
        .id_valid_i    (bus.id_valid),
        .id_rs1_i      (bus.id_rs1),
        .id_rs2_i      (bus.id_rs2),
        .hazard_o      (hazard)
    );

    assign bubble    = bus.flush || hazard;
    assign bus.stall = hazard && !bus.flush && !reset;

    assign id_ctrl = '{reg_write:  bus.id_reg_write,
                       mem_read:   bus.id_mem_read,
                       mem_write:  bus.id_mem_write,
                       mem_to_reg: bus.id_mem_to_reg,
                       alu_src:    bus.id_alu_src,
                       branch:     bus.id_branch,
                       alu_op:     alu_op_e'(bus.id_alu_op)};

    always_comb begin
        valid_d  = 1'b0;
        pc_d     = '0;
        rd1_d    = '0;
        rd2_d    = '0;
        imm_d    = '0;
        rs1_d    = '0;
        rs2_d    = '0;
        rd_d     = '0;
        funct4_d = '0;
        ctrl_d   = CTRL_ZERO;
        cnt_d    = cnt_q;
        if (!bubble) begin
            valid_d  = bus.id_valid;
            pc_d     = bus.id_pc;
            // Register file write and ID read share an edge; forward so EX sees the new value.
            rd1_d    = bypass_hit(bus.wb_reg_write, bus.wb_rd, bus.id_rs1) ? bus.wb_write_data
                                                                            : bus.id_read_data1;
            rd2_d    = bypass_hit(bus.wb_reg_write, bus.wb_rd, bus.id_rs2) ? bus.wb_write_data
                                                                            : bus.id_read_data2;
            imm_d    = bus.id_imm;
            rs1_d    = bus.id_rs1;
            rs2_d    = bus.id_rs2;
            rd_d     = bus.id_rd;
            funct4_d = bus.id_funct4;
            ctrl_d   = id_ctrl;
        end
        if (!bus.flush && hazard && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q  <= 1'b0;
            pc_q     <= '0;
            rd1_q    <= '0;
            rd2_q    <= '0;
            imm_q    <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            funct4_q <= '0;
            ctrl_q   <= CTRL_ZERO;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            pc_q     <= pc_d;
            rd1_q    <= rd1_d;
            rd2_q    <= rd2_d;
            imm_q    <= imm_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            funct4_q <= funct4_d;
            ctrl_q   <= ctrl_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ex_valid      = valid_q;
    assign bus.ex_pc         = pc_q;
    assign bus.ex_read_data1 = rd1_q;
    assign bus.ex_read_data2 = rd2_q;
    assign bus.ex_imm        = imm_q;
    assign bus.ex_rs1        = rs1_q;
    assign bus.ex_rs2        = rs2_q;
    assign bus.ex_rd         = rd_q;
    assign bus.ex_funct4     = funct4_q;
    assign bus.ex_reg_write  = ctrl_q.reg_write;
    assign bus.ex_mem_read   = ctrl_q.mem_read;
    assign bus.ex_mem_write  = ctrl_q.mem_write;
    assign bus.ex_mem_to_reg = ctrl_q.mem_to_reg;
    assign bus.ex_alu_src    = ctrl_q.alu_src;
    assign bus.ex_branch     = ctrl_q.branch;
    assign bus.ex_alu_op     = ctrl_q.alu_op;
    assign bus.stall_count   = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    id_ex_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.id_valid      = 1'b0;
        bus.id_pc         = '0;
        bus.id_read_data1 = '0;
        bus.id_read_data2 = '0;
        bus.id_imm        = '0;
        bus.id_rs1        = '0;
        bus.id_rs2        = '0;
        bus.id_rd         = '0;
        bus.id_funct4     = '0;
        bus.id_reg_write  = 1'b0;
        bus.id_mem_read   = 1'b0;
        bus.id_mem_write  = 1'b0;
        bus.id_mem_to_reg = 1'b0;
        bus.id_alu_src    = 1'b0;
        bus.id_branch     = 1'b0;
        bus.id_alu_op     = 2'b00;
        bus.wb_reg_write  = 1'b0;
        bus.wb_rd         = '0;
        bus.wb_write_data = '0;
        bus.flush         = 1'b0;
    endtask

    // ld x7, 0(x2)
    task automatic present_load();
        idle();
        bus.id_valid      = 1'b1;
        bus.id_pc         = 64'h100;
        bus.id_rs1        = 5'd2;
        bus.id_rd         = 5'd7;
        bus.id_reg_write  = 1'b1;
        bus.id_mem_read   = 1'b1;
        bus.id_mem_to_reg = 1'b1;
        bus.id_alu_src    = 1'b1;
    endtask

    // add x9, x7, x8
    task automatic present_user();
        idle();
        bus.id_valid      = 1'b1;
        bus.id_pc         = 64'h104;
        bus.id_rs1        = 5'd7;
        bus.id_rs2        = 5'd8;
        bus.id_rd         = 5'd9;
        bus.id_reg_write  = 1'b1;
        bus.id_alu_op     = 2'b10;
        bus.id_funct4     = 4'h8;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        reset = 1'b1;
        bus.id_valid      = 1'b1;
        bus.id_read_data1 = {$urandom, $urandom};
        bus.id_read_data2 = {$urandom, $urandom};
        bus.id_imm        = {$urandom, $urandom};
        bus.id_rs1        = 5'($urandom);
        bus.id_rd         = 5'($urandom);
        bus.id_reg_write  = 1'b1;
        bus.id_mem_read   = 1'b1;
        tick();
        tick();
        check("rst_valid", bus.ex_valid, 0);
        check("rst_rd1", bus.ex_read_data1, 0);
        check("rst_imm", bus.ex_imm, 0);
        check("rst_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_alu_op}, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_count", bus.stall_count, 0);

        reset = 1'b0;
        idle();
        bus.id_valid      = 1'b1;
        bus.id_rs1        = 5'd5;
        bus.id_rs2        = 5'd6;
        bus.id_read_data1 = 64'd5;
        bus.id_read_data2 = 64'd6;
        bus.id_imm        = 64'h10;
        bus.id_reg_write  = 1'b1;
        tick();
        check("plain_valid", bus.ex_valid, 1);
        check("plain_rd1", bus.ex_read_data1, 5);
        check("plain_rd2", bus.ex_read_data2, 6);
        check("plain_imm", bus.ex_imm, 64'h10);
        check("plain_regw", bus.ex_reg_write, 1);
        check("plain_rs1", bus.ex_rs1, 5);

        present_load();
        tick();
        check("lu_load_memrd", bus.ex_mem_read, 1);
        present_user();
        #1;
        check("lu_stall", bus.stall, 1);
        tick();
        check("lu_bub_valid", bus.ex_valid, 0);
        check("lu_bub_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_to_reg, bus.ex_alu_op}, 0);
        check("lu_bub_rs1", bus.ex_rs1, 0);
        check("lu_bub_pc", bus.ex_pc, 0);
        check("lu_count", bus.stall_count, 1);
        check("lu_stall_off", bus.stall, 0);
        tick();
        check("lu_rel_valid", bus.ex_valid, 1);
        check("lu_rel_rs1", bus.ex_rs1, 7);
        check("lu_rel_aluop", bus.ex_alu_op, 2);
        check("lu_rel_count", bus.stall_count, 1);

        idle();
        bus.id_valid      = 1'b1;
        bus.id_rs1        = 5'd9;
        bus.id_rs2        = 5'd3;
        bus.id_read_data1 = 64'h99;
        bus.id_read_data2 = 64'd3;
        bus.wb_reg_write  = 1'b1;
        bus.wb_rd         = 5'd3;
        bus.wb_write_data = 64'hDEAD;
        tick();
        check("byp_rd2", bus.ex_read_data2, 64'hDEAD);
        check("byp_rd1_untouched", bus.ex_read_data1, 64'h99);
        bus.id_rs1 = 5'd3;
        bus.id_rs2 = 5'd4;
        tick();
        check("byp_rd1", bus.ex_read_data1, 64'hDEAD);
        check("byp_rd2_untouched", bus.ex_read_data2, 64'd3);
        bus.wb_rd  = 5'd0;
        bus.id_rs2 = 5'd0;
        tick();
        check("byp_x0", bus.ex_read_data2, 64'd3);
        bus.wb_rd        = 5'd3;
        bus.id_rs2       = 5'd3;
        bus.wb_reg_write = 1'b0;
        tick();
        check("byp_nowrite", bus.ex_read_data2, 64'd3);

        present_load();
        tick();
        present_user();
        bus.flush = 1'b1;
        #1;
        check("fl_stall", bus.stall, 0);
        tick();
        check("fl_valid", bus.ex_valid, 0);
        check("fl_ctrl", {bus.ex_reg_write, bus.ex_mem_read, bus.ex_alu_op}, 0);
        check("fl_count", bus.stall_count, 1);

        present_load();
        tick();
        present_user();
        #1;
        check("rh_stall_pre", bus.stall, 1);
        reset = 1'b1;
        #1;
        check("rh_stall_reset", bus.stall, 0);
        tick();
        check("rh_count", bus.stall_count, 0);
        check("rh_valid", bus.ex_valid, 0);
        reset = 1'b0;

        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            present_load();
            tick();
            present_user();
            tick();
            if (i == (1 << CNT_W) - 2)
                check("sat_before", bus.stall_count, (1 << CNT_W) - 1);
        end
        check("sat_count", bus.stall_count, (1 << CNT_W) - 1);
        check("sat_bubble", bus.ex_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 64-bit five-stage pipeline. Sits directly downstream of the register file and captures its two read operands, immediate, register indices and decoded control into the EX-stage register. Adds a WB-to-ID bypass, because a register-file write at the same edge as an ID read would otherwise deliver the stale value. Also detects load-use hazards, inserting one bubble and driving the stall back to PC/IF-ID.

## Interface
Parameters:
- XLEN, 64, datapath width
- CNT_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- id_valid  in  1  ID holds a real instruction
- id_pc, id_read_data1, id_read_data2, id_imm  in  XLEN each  from decode / register file ReadData1, ReadData2
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct4  in  4  {funct7[5], funct3} for ALU control
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  in  1 each  decoded control
- id_alu_op  in  2  ALU op class
- wb_reg_write  in  1  WB write enable, same signal as the register-file RegWrite
- wb_rd  in  5  WB destination, same signal as RD
- wb_write_data  in  XLEN  WB data, same signal as WriteData
- flush  in  1  taken branch resolved downstream; kill the ID instruction
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- ex_valid, ex_pc, ex_read_data1, ex_read_data2, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct4, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_branch, ex_alu_op  out  same widths as id_*  registered EX-stage fields
- stall_count  out  CNT_W  number of load-use bubbles inserted, saturating

## Operation
- **Hazard:** hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2).
  - Compare rs2 unconditionally. A spurious stall on I-type instructions is accepted.
- **Stall output:** stall = hazard & ~flush & ~reset.
- **Bypass operand 1:** op1 = (wb_reg_write & wb_rd != 0 & wb_rd == id_rs1) ? wb_write_data : id_read_data1.
- **Bypass operand 2:** op2 is formed the same way, using id_rs2 and id_read_data2.
  - x0 is never bypassed.
- **Register update priority per edge:** reset > flush > hazard > load.
  - reset: every ex_* output = 0; stall_count = 0.
  - flush: bubble.
  - hazard: bubble; stall_count += 1, saturating at all-ones.
  - load: ex_* ← id_* with op1/op2 substituted; ex_valid ← id_valid.
- **Bubble:** ex_valid and every control, index, data and pc field = 0. Zeroing everything keeps the bubble deterministic.
- **Stall behaviour:** a stalled ID instruction is re-presented by the held IF/ID next cycle. The bubble clears ex_mem_read, so one load-use hazard costs exactly one bubble.
- **Flush during hazard:** flush wins. There is no stall and no count increment.

## Timing
- Latency: id_* sampled at edge N appear on ex_* after edge N; one cycle.
- stall is combinational from the current ex_* registers and id_* inputs; no registered delay.
- Bypass is combinational in the same cycle as the WB write. The value captured equals what the register file will hold after that edge.
- Reset held over multiple cycles keeps all outputs 0 and stall low. Reset mid-hazard drops the hazard immediately.
- stall_count saturates and never wraps. Only reset clears it.

## Structure
- Shared package riscv_pkg holds:
  - XLEN = 64 and REG_IDX_W = 5.
  - ALU_OP encodings: 00 add (load/store), 01 sub (branch), 10 R-type, 11 I-type.
  - A CTRL_ZERO constant for bubble control.
- One sub-module, hazard_detect: combinational load-use compare producing hazard from ex_valid, ex_mem_read, ex_rd, id_valid, id_rs1, id_rs2.
- Bypass muxes and pipeline register live in the top module.

## Test plan
- **Reset:** reset = 1 for 2 cycles with random id_* → all ex_* = 0, stall = 0, stall_count = 0.
- **Plain load:** id_valid = 1, rs1 = 5, rs2 = 6, read_data = 5/6, imm = 0x10, reg_write = 1 → ex_read_data1 = 5, ex_read_data2 = 6, ex_imm = 0x10, ex_reg_write = 1 one cycle later.
- **Load-use:**
  - Stimulus: cycle 1 load `ld x7`; cycle 2 ID holds rs1 = 7.
  - Required response: stall = 1 in cycle 2.
  - Edge after cycle 2: ex_valid = 0 and all control = 0.
  - Cycle 3: stall = 0; the instruction loads normally.
  - stall_count = 1.
- **WB bypass:** wb_reg_write = 1, wb_rd = 3, wb_write_data = 0xDEAD, id_rs2 = 3, id_read_data2 = 3 → ex_read_data2 = 0xDEAD. Same stimulus with wb_rd = 0 and id_rs2 = 0 → the id_read_data2 value passes unchanged.
- **Flush vs hazard:** load-use condition plus flush = 1 → stall = 0, bubble captured, stall_count unchanged.
- **Saturation:** force 2^CNT_W + 3 consecutive load-use hazards → stall_count = all-ones, no wrap.
